// File: rtl/jk_link_pkg.sv
// Shared types and frame layout for the player-state link scheduler.
package jk_link_pkg;

  localparam logic [7:0] HEADER_DEF = 8'hA5;
  localparam int         FRAME_LEN  = 6;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [1:0]  level;
    logic [2:0]  skin;
  } player_state_t;

  typedef enum logic {TX_IDLE, TX_SEND}    tx_state_t;
  typedef enum logic {RX_HUNT, RX_COLLECT} rx_state_t;

  // Byte idx of the wire frame for snapshot s; B5 is the XOR of B1..B4.
  function automatic logic [7:0] frame_byte(input player_state_t s,
                                            input logic [2:0] idx,
                                            input logic [7:0] hdr);
    logic [7:0] b1, b2, b3, b4;
    b1 = s.x[7:0];
    b2 = {s.y[4:0], s.x[10:8]};
    b3 = {s.level, s.y[10:5]};
    b4 = {5'b0, s.skin};
    case (idx)
      3'd0:    frame_byte = hdr;
      3'd1:    frame_byte = b1;
      3'd2:    frame_byte = b2;
      3'd3:    frame_byte = b3;
      3'd4:    frame_byte = b4;
      3'd5:    frame_byte = b1 ^ b2 ^ b3 ^ b4;
      default: frame_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/jk_link_rx.sv
// RX half of the link: header hunt, inter-byte gap timer, checksum check
// and the remote-player register that only ever changes on a whole frame.
module jk_link_rx
  import jk_link_pkg::*;
#(
  parameter logic [7:0] HEADER        = HEADER_DEF,
  parameter int         RX_GAP_CYCLES = 200000
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_valid_i,
  input  logic          clr_valid_i,
  output player_state_t remote_o,
  output logic          remote_valid_o,
  output logic          frame_ok_o,
  output logic          frame_err_o
);

  localparam int GW = $clog2(RX_GAP_CYCLES + 1);

  rx_state_t       state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [3:0][7:0] b_q, b_d;
  logic [7:0]      xor_q, xor_d;
  logic [GW-1:0]   gap_q, gap_d;
  player_state_t   rem_q, rem_d;
  logic            vld_q, vld_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;
  logic            good;

  // Checksum and reserved skin bits are judged when B5 arrives.
  assign good = (xor_q == rx_data_i) && (b_q[3][7:3] == 5'b0);

  // Next-state: frame assembly, gap timeout and remote-state update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    b_d     = b_q;
    xor_d   = xor_q;
    gap_d   = gap_q;
    rem_d   = rem_q;
    vld_d   = vld_q & ~clr_valid_i;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_HUNT: begin
        gap_d = '0;
        if (rx_valid_i && rx_data_i == HEADER) begin
          state_d = RX_COLLECT;
          idx_d   = 3'd1;
          xor_d   = 8'h00;
        end
      end
      RX_COLLECT: begin
        if (rx_valid_i) begin
          gap_d = '0;
          if (idx_q == 3'(FRAME_LEN - 1)) begin
            state_d = RX_HUNT;
            if (good) begin
              rem_d = '{x:     {b_q[1][2:0], b_q[0]},
                        y:     {b_q[2][5:0], b_q[1][7:3]},
                        level: b_q[2][7:6],
                        skin:  b_q[3][2:0]};
              vld_d = 1'b1;
              ok_d  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            // A HEADER value here is plain data; no resync mid-frame.
            b_d[2'(idx_q - 3'd1)] = rx_data_i;
            xor_d = xor_q ^ rx_data_i;
            idx_d = idx_q + 3'd1;
          end
        end else if (gap_q == GW'(RX_GAP_CYCLES - 1)) begin
          state_d = RX_HUNT;
          gap_d   = '0;
          err_d   = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = RX_HUNT;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= RX_HUNT;
      idx_q   <= '0;
      b_q     <= '0;
      xor_q   <= '0;
      gap_q   <= '0;
      rem_q   <= '0;
      vld_q   <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      b_q     <= b_d;
      xor_q   <= xor_d;
      gap_q   <= gap_d;
      rem_q   <= rem_d;
      vld_q   <= vld_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign remote_o       = rem_q;
  assign remote_valid_o = vld_q;
  assign frame_ok_o     = ok_q;
  assign frame_err_o    = err_q;

endmodule

// File: rtl/jk_link_sched.sv
// Player-state link scheduler: frames the local player state onto one UART
// byte stream and rebuilds the remote player from the incoming stream.
// Optional link-loss watchdog: define JK_LINK_WATCHDOG_EN.
module jk_link_sched
  import jk_link_pkg::*;
#(
  parameter logic [7:0] HEADER        = HEADER_DEF,
  parameter int         RX_GAP_CYCLES = 200000
`ifdef JK_LINK_WATCHDOG_EN
  , parameter int       TIMEOUT_FRAMES = 30
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [10:0] x_pos,
  input  logic [10:0] y_pos,
  input  logic [1:0]  level,
  input  logic [2:0]  skin,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [10:0] remote_x,
  output logic [10:0] remote_y,
  output logic [1:0]  remote_level,
  output logic [2:0]  remote_skin,
  output logic        remote_valid,
  output logic        frame_ok,
  output logic        frame_err
);

  tx_state_t     state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  player_state_t snap_q, snap_d;
  logic          pend_q, pend_d;
  player_state_t live, remote;
  logic          clr_valid;

  assign live = '{x: x_pos, y: y_pos, level: level, skin: skin};

  // TX next-state: snapshot on tick, walk the bytes, chain a pending frame.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    pend_d  = pend_q;
    case (state_q)
      TX_IDLE: begin
        if (frame_tick) begin
          snap_d  = live;
          idx_d   = 3'd0;
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (frame_tick) pend_d = 1'b1;
        if (tx_ready) begin
          if (idx_q == 3'(FRAME_LEN - 1)) begin
            // A tick landing on the last beat counts as pending too.
            if (pend_q || frame_tick) begin
              snap_d = live;
              idx_d  = 3'd0;
              pend_d = 1'b0;
            end else begin
              state_d = TX_IDLE;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // TX state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= TX_IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      pend_q  <= pend_d;
    end
  end

  // Bytes come from the registered snapshot, so they hold under backpressure.
  assign tx_valid = (state_q == TX_SEND);
  assign tx_data  = tx_valid ? frame_byte(snap_q, idx_q, HEADER) : 8'h00;

`ifdef JK_LINK_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT_FRAMES + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          wd_exp;

  assign wd_exp = (wd_q == WW'(TIMEOUT_FRAMES));

  // Watchdog next-state: count ticks since the last good frame, saturating.
  always_comb begin
    wd_d = wd_q;
    if (frame_ok)                 wd_d = '0;
    else if (frame_tick && !wd_exp) wd_d = wd_q + 1'b1;
  end

  // Watchdog register.
  always_ff @(posedge clk) begin
    if (!rst) wd_q <= '0;
    else      wd_q <= wd_d;
  end

  // Hold off the clear in the cycle a fresh good frame is reported.
  assign clr_valid = wd_exp && !frame_ok;
`else
  assign clr_valid = 1'b0;
`endif

  jk_link_rx #(
    .HEADER        (HEADER),
    .RX_GAP_CYCLES (RX_GAP_CYCLES)
  ) u_rx (
    .clk_i          (clk),
    .rst_ni         (rst),
    .rx_data_i      (rx_data),
    .rx_valid_i     (rx_valid),
    .clr_valid_i    (clr_valid),
    .remote_o       (remote),
    .remote_valid_o (remote_valid),
    .frame_ok_o     (frame_ok),
    .frame_err_o    (frame_err)
  );

  assign remote_x     = remote.x;
  assign remote_y     = remote.y;
  assign remote_level = remote.level;
  assign remote_skin  = remote.skin;

endmodule

// File: tb/tb_jk_link_sched.sv
// Directed-plus-random bench for jk_link_sched against a frame-level model.
module tb_jk_link_sched;

  localparam int GAP = 40;
  typedef logic [7:0] frm_t [6];

  logic        clk = 1'b0, rst = 1'b0, frame_tick = 1'b0;
  logic        tx_ready = 1'b0, rx_valid = 1'b0;
  logic [10:0] x_pos = '0, y_pos = '0;
  logic [1:0]  level = '0;
  logic [2:0]  skin = '0;
  logic [7:0]  rx_data = '0;
  logic [7:0]  tx_data;
  logic        tx_valid, remote_valid, frame_ok, frame_err;
  logic [10:0] remote_x, remote_y;
  logic [1:0]  remote_level;
  logic [2:0]  remote_skin;

  always #5 clk = ~clk;

  jk_link_sched #(.RX_GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .x_pos(x_pos), .y_pos(y_pos), .level(level), .skin(skin),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .remote_x(remote_x), .remote_y(remote_y), .remote_level(remote_level),
    .remote_skin(remote_skin), .remote_valid(remote_valid),
    .frame_ok(frame_ok), .frame_err(frame_err)
  );

  int total = 0, bad = 0;
  int ok_cnt = 0, err_cnt = 0, exp_ok = 0, exp_err = 0;
  int ex = 0, ey = 0, el = 0, es = 0, ev = 0;
  logic [7:0] cap[$];

  // Observe accepted TX bytes and RX pulses mid-cycle.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) cap.push_back(tx_data);
    if (frame_ok)  ok_cnt++;
    if (frame_err) err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame built from the field layout with plain arithmetic.
  function automatic frm_t mk(input int x, input int y, input int l, input int s);
    frm_t f;
    f[0] = 8'hA5;
    f[1] = 8'(x % 256);
    f[2] = 8'((y % 32) * 8 + x / 256);
    f[3] = 8'(l * 64 + y / 32);
    f[4] = 8'(s);
    f[5] = f[1] ^ f[2] ^ f[3] ^ f[4];
    return f;
  endfunction

  task automatic set_local(input int x, input int y, input int l, input int s);
    x_pos = 11'(x); y_pos = 11'(y); level = 2'(l); skin = 3'(s);
  endtask

  task automatic tick_pulse();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (cap.size() < n && k < budget) begin step(); k++; end
    chk("tx_wait", 32'(cap.size() >= n), 1);
  endtask

  task automatic tx_expect(input frm_t f, input int base);
    for (int i = 0; i < 6; i++)
      if (base + i < cap.size()) chk($sformatf("tx_b%0d", base + i), cap[base + i], f[i]);
  endtask

  task automatic check_remote(input string tag);
    chk({tag, "_x"}, remote_x, ex);
    chk({tag, "_y"}, remote_y, ey);
    chk({tag, "_lvl"}, remote_level, el);
    chk({tag, "_skin"}, remote_skin, es);
    chk({tag, "_vld"}, remote_valid, ev);
  endtask

  task automatic rx_byte(input logic [7:0] b, input int gap);
    rx_data = b; rx_valid = 1'b1; step(); rx_valid = 1'b0;
    rx_data = 8'($urandom); step(gap);
  endtask

  // Feed a whole frame and judge it with the model's own acceptance rule.
  task automatic feed(input frm_t f, input int lo, input int hi, input string tag);
    logic good;
    for (int i = 0; i < 5; i++) rx_byte(f[i], $urandom_range(hi, lo));
    rx_data = f[5]; rx_valid = 1'b1; step(); rx_valid = 1'b0;
    good = ((f[1] ^ f[2] ^ f[3] ^ f[4]) == f[5]) && (f[4] < 8);
    if (good) begin
      ex = int'(f[1]) + (int'(f[2]) % 8) * 256;
      ey = int'(f[2]) / 8 + (int'(f[3]) % 64) * 32;
      el = int'(f[3]) / 64;
      es = int'(f[4]);
      ev = 1;
      exp_ok++;
    end else begin
      exp_err++;
    end
    check_remote(tag);
    chk({tag, "_okpulse"}, frame_ok, good);
    chk({tag, "_errpulse"}, frame_err, !good);
    step();
    chk({tag, "_okcnt"}, ok_cnt, exp_ok);
    chk({tag, "_errcnt"}, err_cnt, exp_err);
  endtask

  frm_t f1, f2;
  int   nx, ny, nl, ns;

  initial begin
    // Reset held with random activity on every input.
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      frame_tick = 1'($urandom); tx_ready = 1'($urandom);
      rx_valid = 1'($urandom); rx_data = 8'($urandom);
      set_local($urandom, $urandom, $urandom, $urandom);
      step();
    end
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_ok", frame_ok, 0);
    chk("rst_err", frame_err, 0);
    check_remote("rst");
    frame_tick = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    cap.delete();

    // Directed TX frame with the ready line held high.
    set_local(12'h123, 12'h2A5, 2, 5);
    f1 = mk(12'h123, 12'h2A5, 2, 5);
    tx_ready = 1'b1;
    tick_pulse();
    chk("tx_first_vld", tx_valid, 1);
    chk("tx_first_hdr", tx_data, 8'hA5);
    wait_bytes(6, 20);
    step(2);
    chk("tx_idle_after", tx_valid, 0);
    chk("tx_cnt1", cap.size(), 6);
    tx_expect(f1, 0);

    // Backpressure at B3, two ticks during SEND, then one chained frame.
    cap.delete();
    tick_pulse();
    wait_bytes(3, 20);
    tx_ready = 1'b0;
    nx = $urandom_range(2047); ny = $urandom_range(2047);
    nl = $urandom_range(3);    ns = $urandom_range(7);
    for (int c = 0; c < 10; c++) begin
      chk("bp_data", tx_data, f1[3]);
      chk("bp_vld", tx_valid, 1);
      if (c == 1) set_local(nx, ny, nl, ns);
      frame_tick = (c == 2 || c == 6);
      step();
    end
    frame_tick = 1'b0;
    chk("bp_noskip", cap.size(), 3);
    tx_ready = 1'b1;
    step(9);
    chk("bp_b2b", cap.size(), 12);
    step(3);
    chk("bp_idle", tx_valid, 0);
    chk("bp_onlyone", cap.size(), 12);
    f2 = mk(nx, ny, nl, ns);
    tx_expect(f1, 0);
    tx_expect(f2, 6);

    // Random TX frames under random ready.
    for (int r = 0; r < 3; r++) begin
      cap.delete();
      nx = $urandom_range(2047); ny = $urandom_range(2047);
      nl = $urandom_range(3);    ns = $urandom_range(7);
      set_local(nx, ny, nl, ns);
      tx_ready = 1'($urandom);
      tick_pulse();
      for (int k = 0; k < 200 && cap.size() < 6; k++) begin
        chk("rnd_hold", tx_valid, 1);
        tx_ready = 1'($urandom);
        step();
      end
      tx_ready = 1'b1;
      step(2);
      chk("rnd_cnt", cap.size(), 6);
      chk("rnd_idle", tx_valid, 0);
      tx_expect(mk(nx, ny, nl, ns), 0);
    end

    // RX: stray byte, then the directed good frame.
    rx_byte(8'h00, 1);
    feed(mk(12'h123, 12'h2A5, 2, 5), 0, 2, "rx_good");

    // RX: random good frames, one with a HEADER-valued data byte.
    for (int r = 0; r < 3; r++) begin
      nx = (r == 0) ? 12'h1A5 : $urandom_range(2047);
      feed(mk(nx, $urandom_range(2047), $urandom_range(3), $urandom_range(7)), 0, 3, "rx_rnd");
    end

    // RX: bad checksum, then reserved skin bits set with a valid checksum.
    f1 = mk(12'h123, 12'h2A5, 2, 5);
    f1[5] = 8'h9B;
    feed(f1, 0, 2, "rx_badcs");
    f1 = mk($urandom_range(2047), $urandom_range(2047), $urandom_range(3), $urandom_range(7));
    f1[4] = f1[4] | 8'h40;
    f1[5] = f1[1] ^ f1[2] ^ f1[3] ^ f1[4];
    feed(f1, 0, 2, "rx_badskin");

    // RX: stall after B2 past the gap limit.
    f1 = mk($urandom_range(2047), $urandom_range(2047), $urandom_range(3), $urandom_range(7));
    rx_byte(f1[0], 0); rx_byte(f1[1], 0); rx_byte(f1[2], 0);
    step(GAP + 5);
    exp_err++;
    chk("gap_errcnt", err_cnt, exp_err);
    chk("gap_okcnt", ok_cnt, exp_ok);
    check_remote("gap_hold");
    // Gaps just under the limit are still one frame.
    feed(mk($urandom_range(2047), $urandom_range(2047), $urandom_range(3), $urandom_range(7)),
         GAP - 4, GAP - 3, "gap_near");

    // Reset in the middle of an RX frame and a TX frame.
    tx_ready = 1'b0;
    tick_pulse();
    chk("mid_txv", tx_valid, 1);
    f1 = mk(12'h123, 12'h2A5, 2, 5);
    for (int i = 0; i < 4; i++) rx_byte(f1[i], 0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    ex = 0; ey = 0; el = 0; es = 0; ev = 0;
    check_remote("mid_rst");
    chk("mid_rst_txv", tx_valid, 0);
    tx_ready = 1'b1;
    rx_byte(f1[4], 0); rx_byte(f1[5], 2);
    chk("mid_tail_ok", ok_cnt, exp_ok);
    chk("mid_tail_err", err_cnt, exp_err);
    chk("mid_tail_txv", tx_valid, 0);
    feed(mk($urandom_range(2047), $urandom_range(2047), $urandom_range(3), $urandom_range(7)),
         0, 2, "post_rst");

    // Link-loss behaviour over 30 ticks with no RX traffic.
    for (int t = 0; t < 29; t++) begin tick_pulse(); step(2); end
    chk("wd_before", remote_valid, 1);
    tick_pulse();
    step(2);
`ifdef JK_LINK_WATCHDOG_EN
    ev = 0;
    check_remote("wd_lost");
    feed(mk($urandom_range(2047), $urandom_range(2047), $urandom_range(3), $urandom_range(7)),
         0, 2, "wd_back");
`else
    check_remote("sticky");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
